// File: rtl/dplca_txop_claim_tracker_pkg.sv
// Shared 802.3da DPLCA encodings: PLCA rx_cmd values and the
// claim-tracker state codes.
package dplca_txop_claim_tracker_pkg;

   typedef enum logic [1:0] {
      CMD_BEACON = 2'b00,
      CMD_COMMIT = 2'b01,
      CMD_NONE   = 2'b10
   } rx_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_TRACK,
      ST_TXOP_DONE,
      ST_AGE
   } state_e;

   localparam int ID_W = 8;

endpackage

// File: rtl/dplca_txop_claim_tracker_if.sv
// Bundle between the PLCA observer side (master) and the
// TXOP claim tracker (slave).
interface dplca_txop_claim_tracker_if #(
   parameter int AGE_W  = 16,
   parameter int MAX_ID = 255
);
   logic             plca_reset;
   logic             dplca_aging;
   logic [AGE_W-1:0] aging_cycles;
   logic [1:0]       rx_cmd;
   logic [7:0]       cur_id;
   logic [7:0]       plca_node_count;
   logic             txop_end;
   logic             rx_activity;
   logic             tx_activity;
   logic             dplca_txop_table_upd;
   logic             dplca_new_age;
   logic [7:0]       dplca_txop_id;
   logic [7:0]       dplca_txop_node_count;
   logic [MAX_ID:0]  txop_claim_table;

   modport master (
      output plca_reset, dplca_aging, aging_cycles, rx_cmd,
      output cur_id, plca_node_count, txop_end,
      output rx_activity, tx_activity,
      input  dplca_txop_table_upd, dplca_new_age,
      input  dplca_txop_id, dplca_txop_node_count,
      input  txop_claim_table
   );

   modport slave (
      input  plca_reset, dplca_aging, aging_cycles, rx_cmd,
      input  cur_id, plca_node_count, txop_end,
      input  rx_activity, tx_activity,
      output dplca_txop_table_upd, dplca_new_age,
      output dplca_txop_id, dplca_txop_node_count,
      output txop_claim_table
   );
endinterface

// File: rtl/dplca_age_counter.sv
// BEACON edge detector and saturating PLCA-cycle window counter;
// pulses age_due_o on the edge that completes an aging window.
module dplca_age_counter
   import dplca_txop_claim_tracker_pkg::*;
#(
   parameter int AGE_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             plca_reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [1:0]       rx_cmd_i,
   input  logic [AGE_W-1:0] aging_cycles_i,
   output logic             beacon_edge_o,
   output logic             age_due_o
);
   logic             prev_q;
   logic             is_beacon;
   logic [AGE_W-1:0] cnt_q;
   logic [AGE_W-1:0] cnt_d;
   logic [AGE_W-1:0] lim;
   logic [AGE_W:0]   nxt;

   always_comb begin
      is_beacon     = (rx_cmd_i == CMD_BEACON);
      beacon_edge_o = is_beacon & ~prev_q;
      lim = (aging_cycles_i == '0) ? AGE_W'(1) : aging_cycles_i;
      nxt = {1'b0, cnt_q} + (AGE_W+1)'(1);
      age_due_o = en_i & beacon_edge_o & (nxt >= {1'b0, lim});
      cnt_d = cnt_q;
      if (clr_i || age_due_o)
         cnt_d = '0;
      else if (en_i && beacon_edge_o && !(&cnt_q))
         cnt_d = cnt_q + AGE_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else if (plca_reset_i) begin
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prev_q <= is_beacon;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/dplca_txop_claim_tracker.sv
// DPLCA TXOP claim tracker: records claimed TO IDs per aging window
// and feeds the node-ID state machine with table/ID updates.
module dplca_txop_claim_tracker
   import dplca_txop_claim_tracker_pkg::*;
#(
   parameter int AGE_W  = 16,
   parameter int MAX_ID = 255
) (
   input logic                  clk,
   input logic                  reset_n,
   dplca_txop_claim_tracker_if.slave bus
);
   localparam int TW = MAX_ID + 1;

   state_e          st_q;
   logic [TW-1:0]   work_q, work_d;
   logic [TW-1:0]   aged_q, aged_d;
   logic [TW-1:0]   tbl_q, mask;
   logic            claim_q, act, claim;
   logic            run, trk, age_req, age_pend_q;
   logic            go_done, go_age;
   logic            beacon_edge, age_due;
   logic            upd_q, new_age_q;
   logic [ID_W-1:0] id_q, nc_q;

   dplca_age_counter #(.AGE_W(AGE_W)) u_age (
      .clk            (clk),
      .reset_n        (reset_n),
      .plca_reset_i   (bus.plca_reset),
      .clr_i          (!trk),
      .en_i           (trk),
      .rx_cmd_i       (bus.rx_cmd),
      .aging_cycles_i (bus.aging_cycles),
      .beacon_edge_o  (beacon_edge),
      .age_due_o      (age_due)
   );

   always_comb begin
      run   = bus.dplca_aging;
      trk   = st_q inside {ST_TRACK, ST_TXOP_DONE, ST_AGE};
      act   = bus.rx_activity | bus.tx_activity
            | (bus.rx_cmd == CMD_COMMIT);
      claim = claim_q | act;
      age_req = age_due | age_pend_q;
      go_done = run && st_q == ST_TRACK && bus.txop_end;
      // TXOP close wins; a coincident window end ages one clk later
      go_age  = run && age_req
             && ((st_q == ST_TRACK && !bus.txop_end)
             ||  st_q == ST_TXOP_DONE);
      // IDs beyond the table shift out, so they never write a bit
      mask   = (go_done && claim) ? (TW'(1) << bus.cur_id) : '0;
      work_d = go_age ? '0 : (work_q | mask);
      aged_d = go_age ? work_q : aged_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q       <= ST_IDLE;
         work_q     <= '0;
         aged_q     <= '0;
         tbl_q      <= '0;
         claim_q    <= 1'b0;
         age_pend_q <= 1'b0;
         upd_q      <= 1'b0;
         new_age_q  <= 1'b0;
         id_q       <= '0;
         nc_q       <= '0;
      end else if (bus.plca_reset) begin
         st_q       <= ST_IDLE;
         work_q     <= '0;
         aged_q     <= '0;
         tbl_q      <= '0;
         claim_q    <= 1'b0;
         age_pend_q <= 1'b0;
         upd_q      <= 1'b0;
         new_age_q  <= 1'b0;
         id_q       <= '0;
         nc_q       <= '0;
      end else begin
         work_q     <= work_d;
         aged_q     <= aged_d;
         tbl_q      <= work_d | aged_d;
         upd_q      <= go_done;
         new_age_q  <= go_age;
         age_pend_q <= run & trk & age_req & ~go_age;
         if (go_done) begin
            id_q <= bus.cur_id;
            nc_q <= bus.plca_node_count;
         end
         if (!run) begin
            st_q    <= ST_IDLE;
            claim_q <= 1'b0;
         end else begin
            unique case (st_q)
               ST_IDLE: begin
                  st_q    <= ST_SYNC;
                  claim_q <= 1'b0;
               end
               ST_SYNC: begin
                  if (beacon_edge) st_q <= ST_TRACK;
                  claim_q <= 1'b0;
               end
               ST_TRACK: begin
                  claim_q <= claim & ~bus.txop_end;
                  if (bus.txop_end) st_q <= ST_TXOP_DONE;
                  else if (age_req) st_q <= ST_AGE;
               end
               ST_TXOP_DONE: begin
                  claim_q <= act;
                  st_q    <= age_req ? ST_AGE : ST_TRACK;
               end
               ST_AGE: begin
                  claim_q <= claim;
                  st_q    <= ST_TRACK;
               end
               default: st_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.dplca_txop_table_upd  = upd_q;
   assign bus.dplca_new_age         = new_age_q;
   assign bus.dplca_txop_id         = id_q;
   assign bus.dplca_txop_node_count = nc_q;
   assign bus.txop_claim_table      = tbl_q;
endmodule

// File: doc/dplca_txop_claim_tracker.md
Name: dplca_txop_claim_tracker

Overview:
- Synthesizable producer of the DPLCA TXOP claim information consumed by the DPLCA node-ID state machine.
- Observes PLCA transmit opportunities (TOs) on the mixing segment and records which TO IDs are claimed.
- Ages the claim table over a programmable number of PLCA cycles.
- Generates the dplca_txop_table_upd and dplca_new_age strobes, together with dplca_txop_id, dplca_txop_node_count and txop_claim_table.

Parameters:
- AGE_W, 16, width of aging_cycles and the internal cycle counter.
- MAX_ID, 255, highest TO ID tracked; the table is MAX_ID+1 bits wide.

Ports:
- clk  input  1  reference clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- plca_reset  input  1  synchronous clear, same effect as reset
- dplca_aging  input  1  aging enable from the DPLCA state machine
- aging_cycles  input  AGE_W  PLCA cycles per aging window
- rx_cmd  input  2  BEACON=00, COMMIT=01, NONE=10
- cur_id  input  8  TO ID currently owning the medium (PLCA control curID)
- plca_node_count  input  8  current node count
- txop_end  input  1  one-clk pulse when the TO for cur_id closes
- rx_activity  input  1  carrier or receive data observed in current TO
- tx_activity  input  1  local transmit (COMMIT or data) in current TO
- dplca_txop_table_upd  output  1  one-clk pulse, table/ID outputs updated
- dplca_new_age  output  1  one-clk pulse, aging window completed
- dplca_txop_id  output  8  ID of the TO just closed
- dplca_txop_node_count  output  8  plca_node_count sampled at that TO close
- txop_claim_table  output  MAX_ID+1  bit i = TO i claimed in the last completed window OR the current window

Behaviour:
- Reset and plca_reset: all outputs 0, both internal banks cleared, cycle count 0, state IDLE.
- Internal storage: work[] (claims in the current window) and aged[] (claims in the last completed window). txop_claim_table = work | aged, registered.
- States:
  - IDLE: wait for dplca_aging=1, then go to SYNC.
  - SYNC: wait for the first rx_cmd==BEACON edge (transition from non-BEACON to BEACON), then go to TRACK.
  - TRACK: latch claim_pending on rx_activity | tx_activity | rx_cmd==COMMIT. On txop_end, go to TXOP_DONE.
  - TXOP_DONE (1 clk):
    - if claim_pending and cur_id<=MAX_ID, set work[cur_id];
    - latch dplca_txop_id=cur_id and dplca_txop_node_count=plca_node_count;
    - pulse dplca_txop_table_upd;
    - clear claim_pending; return to TRACK.
  - AGE (1 clk): aged<=work; work<=0; pulse dplca_new_age; return to TRACK.
- Latency: dplca_txop_table_upd is high in the clk after the txop_end sample, and all data outputs are valid in that same clk.
- Cycle counting: each BEACON edge in TRACK increments the cycle count. When count+1 >= max(aging_cycles,1), the count resets to 0 and the state goes to AGE instead of staying in TRACK.
- Simultaneous txop_end and BEACON edge: TXOP_DONE is processed first, and the aging decision is deferred one clk, so AGE follows TXOP_DONE. dplca_new_age is never coincident with dplca_txop_table_upd.
- Write in the AGE clk: a claim latched during the AGE clk goes to the new work bank and is not lost.
- aging_cycles=0 behaves as 1.
- A change of aging_cycles takes effect at the next BEACON edge.
- dplca_aging deasserted in any state: return to IDLE next clk. Banks and outputs are held, not cleared, so the consumer still sees the last table. Re-enable re-enters SYNC.
- Counter width: the cycle counter saturates and never wraps.
- cur_id > MAX_ID: ignored for table writes; the update strobe is still generated.
- reset_n asserted mid-operation: immediate clear regardless of state.

Decomposition:
- rx_cmd encodings (BEACON/COMMIT/NONE) and state encodings belong in the shared 802.3da parameter include; no local redefinition.
- One natural sub-module: dplca_age_counter. It contains the beacon-edge detector and the saturating window counter, and outputs an age_due pulse.

Test Plan:
- Reset sanity: hold reset_n low, drive arbitrary inputs -> all outputs 0. Release with dplca_aging=0 -> state stays IDLE, no strobes.
- Single claim: aging_cycles=4, BEACON edge, then a TO with cur_id=3, rx_activity=1, txop_end -> dplca_txop_table_upd one clk later, dplca_txop_id=3, table bit 3 set.
- Unclaimed TO: cur_id=5, no activity, txop_end -> strobe asserted, dplca_txop_id=5, bit 5 stays 0.
- Aging: claim ID 3 in cycle 1 only, run 4 cycles -> dplca_new_age after the 4th BEACON edge, bit 3 still set (aged bank). After a further 4 unclaimed cycles, bit 3 clears.
- Simultaneous events: txop_end for ID 7 in the same clk as the BEACON edge that completes the window -> table_upd in clk N+1, new_age in clk N+2, bit 7 present in the aged bank.
- Edge values: aging_cycles=0 -> new_age every cycle. cur_id=255 claimed -> bit 255 set. plca_reset pulse mid-window -> table 0, returns to IDLE/SYNC.
